// File: rtl/gpio_input_port_pkg.sv
// -----------------------------------------------------------------------------
// gpio_input_port_pkg
// Shared default parameter values for the GPIO input port slice.
// Ports: none (package only).
// -----------------------------------------------------------------------------
package gpio_input_port_pkg;

    // Number of board input pins.
    localparam int DEFAULT_WIDTH           = 8;
    // 1 ms of stability at the 16 MHz core clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16000;
    // Wide enough to hold DEFAULT_DEBOUNCE_CYCLES-1.
    localparam int DEFAULT_CNT_WIDTH       = 16;

endpackage : gpio_input_port_pkg

// File: rtl/gpio_input_port_if.sv
// -----------------------------------------------------------------------------
// gpio_input_port_if
// Groups the board pins and the CPU-facing signals of the GPIO input port.
//   i_pins    : raw asynchronous pin levels (board -> port)
//   i_read    : one-cycle CPU read/acknowledge strobe (CPU -> port)
//   o_data    : debounced stable pin levels (port -> CPU)
//   o_changed : sticky per-bit change flags (port -> CPU)
//   o_valid   : OR of o_changed (port -> CPU)
// Modports: master = CPU/board side, slave = the peripheral.
// -----------------------------------------------------------------------------
interface gpio_input_port_if
    import gpio_input_port_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] i_pins;
    logic             i_read;
    logic [WIDTH-1:0] o_data;
    logic [WIDTH-1:0] o_changed;
    logic             o_valid;

    modport master (
        output i_pins,
        output i_read,
        input  o_data,
        input  o_changed,
        input  o_valid
    );

    modport slave (
        input  i_pins,
        input  i_read,
        output o_data,
        output o_changed,
        output o_valid
    );

endinterface : gpio_input_port_if

// File: rtl/gpio_input_port_debounce_bit.sv
// -----------------------------------------------------------------------------
// gpio_input_port_debounce_bit
// Synchronizes and debounces one asynchronous input pin.
//   i_clk   : core clock
//   i_reset : synchronous, active-high reset
//   i_pin   : raw asynchronous pin level
//   o_level : debounced stable level (registered)
//   o_event : high during the cycle whose rising edge accepts a new level
// -----------------------------------------------------------------------------
module gpio_input_port_debounce_bit
    import gpio_input_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
)(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_event
);

    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1;
    logic                 sync2;
    logic [CNT_WIDTH-1:0] count;
    logic                 mismatch;

    assign mismatch = (sync2 != o_level);

    // Combinational so the flag logic in the parent sets o_changed on the
    // same edge that o_level takes the new value.
    assign o_event = mismatch && (count >= LAST_COUNT);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would collapse the
    // two-stage synchronizer into a single flop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            count   <= '0;
            o_level <= 1'b0;
        end else begin
            sync1 <= i_pin;
            sync2 <= sync1;
            if (!mismatch) begin
                // Any agreeing cycle discards progress: bouncing restarts.
                count <= '0;
            end else if (o_event) begin
                o_level <= sync2;
                count   <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule : gpio_input_port_debounce_bit

// File: rtl/gpio_input_port.sv
// -----------------------------------------------------------------------------
// gpio_input_port
// CPU-facing input peripheral: per-pin synchronizer and debounce, stable
// levels, and sticky change flags cleared by a one-cycle read strobe.
//   i_clk   : core clock (16 MHz)
//   i_reset : synchronous, active-high reset
//   bus     : gpio_input_port_if.slave (i_pins, i_read, o_data, o_changed,
//             o_valid)
// -----------------------------------------------------------------------------
module gpio_input_port
    import gpio_input_port_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
)(
    input  logic                i_clk,
    input  logic                i_reset,
    gpio_input_port_if.slave    bus
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] events;
    logic [WIDTH-1:0] changed_next;

    for (genvar n = 0; n < WIDTH; n++) begin : g_bit
        gpio_input_port_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_debounce (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_pin   (bus.i_pins[n]),
            .o_level (level[n]),
            .o_event (events[n])
        );
    end

    assign bus.o_data = level;

    // NOTE: changed_next gets its default before any condition so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        changed_next = bus.o_changed;
        if (bus.i_read) begin
            changed_next = '0;
        end
        // Applied after the clear so an event on the read cycle is kept.
        changed_next = changed_next | events;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bus.o_changed <= '0;
            bus.o_valid   <= 1'b0;
        end else begin
            bus.o_changed <= changed_next;
            bus.o_valid   <= |changed_next;
        end
    end

endmodule : gpio_input_port

// File: tb/tb_gpio_input_port.sv
// -----------------------------------------------------------------------------
// tb_gpio_input_port
// Directed self-checking bench for gpio_input_port with DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_gpio_input_port;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;

    int n_cmp = 0;
    int n_err = 0;

    gpio_input_port_if #(.WIDTH(WIDTH)) bus ();

    gpio_input_port #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (4),
        .CNT_WIDTH       (16)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] data,
                             input logic [WIDTH-1:0] changed, input logic valid);
        check({tag, ".data"},    bus.o_data,            data);
        check({tag, ".changed"}, bus.o_changed,         changed);
        check({tag, ".valid"},   WIDTH'(bus.o_valid),   WIDTH'(valid));
    endtask

    initial begin
        rst        = 1'b1;
        bus.i_pins = 8'h00;
        bus.i_read = 1'b0;
        tick(2);
        rst = 1'b0;
        check_all("reset", 8'h00, 8'h00, 1'b0);

        // Idle with pins low: nothing may move.
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_all("idle", 8'h00, 8'h00, 1'b0);
        end

        // 0x00 -> 0xA5 held: accepted exactly 6 edges later.
        bus.i_pins = 8'hA5;
        tick(5);
        check_all("a5_edge5", 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("a5_edge6", 8'hA5, 8'hA5, 1'b1);

        // Single read clears every flag.
        bus.i_read = 1'b1;
        tick(1);
        bus.i_read = 1'b0;
        check_all("read_clear", 8'hA5, 8'h00, 1'b0);

        // Read while nothing is flagged has no effect.
        bus.i_read = 1'b1;
        tick(1);
        bus.i_read = 1'b0;
        check_all("read_idle", 8'hA5, 8'h00, 1'b0);

        // 3-cycle pulse on bit 1: below threshold, ignored.
        bus.i_pins = 8'hA7;
        tick(3);
        bus.i_pins = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check_all("pulse3", 8'hA5, 8'h00, 1'b0);
        end

        // 4-cycle pulse on bit 1: accepted 6 edges after the rise.
        bus.i_pins = 8'hA7;
        tick(4);
        bus.i_pins = 8'hA5;
        check_all("pulse4_edge4", 8'hA5, 8'h00, 1'b0);
        tick(1);
        check_all("pulse4_edge5", 8'hA5, 8'h00, 1'b0);
        tick(1);
        check_all("pulse4_edge6", 8'hA7, 8'h02, 1'b1);
        // Clear on edge 7.
        bus.i_read = 1'b1;
        tick(1);
        bus.i_read = 1'b0;
        check_all("pulse4_clear", 8'hA7, 8'h00, 1'b0);
        tick(2);
        check_all("pulse4_edge9", 8'hA7, 8'h00, 1'b0);
        // Falling edge of bit 1 is accepted on edge 10, same cycle as a read.
        bus.i_read = 1'b1;
        tick(1);
        bus.i_read = 1'b0;
        check_all("set_wins", 8'hA5, 8'h02, 1'b1);
        bus.i_read = 1'b1;
        tick(1);
        bus.i_read = 1'b0;
        check_all("pre_bounce_clear", 8'hA5, 8'h00, 1'b0);

        // Bounce bit 3: only the final run of four is accepted (edge 11).
        begin
            logic [8:0] pattern;
            pattern = 9'b111101101;  // applied LSB first: 1,0,1,1,0,1,1,1,1
            for (int i = 0; i < 9; i++) begin
                bus.i_pins = {4'hA, pattern[i], 3'b101};
                tick(1);
            end
        end
        check_all("bounce_edge9", 8'hA5, 8'h00, 1'b0);
        tick(1);
        check_all("bounce_edge10", 8'hA5, 8'h00, 1'b0);
        tick(1);
        check_all("bounce_edge11", 8'hAD, 8'h08, 1'b1);

        // Read held for several cycles clears every cycle.
        bus.i_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_all("read_held", 8'hAD, 8'h00, 1'b0);
        end
        bus.i_read = 1'b0;
        // No second event from the bounce.
        tick(6);
        check_all("bounce_single", 8'hAD, 8'h00, 1'b0);

        // Bit 0 falls: o_changed becomes 0x01.
        bus.i_pins = 8'hAC;
        tick(6);
        check_all("bit0_fall", 8'hAC, 8'h01, 1'b1);

        // Bit 4 rises; reset lands with its counter at 2.
        bus.i_pins = 8'hBC;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_all("mid_reset", 8'h00, 8'h00, 1'b0);

        // Synchronizers restart: held pins appear 6 edges after release.
        tick(5);
        check_all("post_reset_edge5", 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("post_reset_edge6", 8'hBC, 8'hBC, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_gpio_input_port
